// File: rtl/ball_motion_engine_if.sv
// rtl/ball_motion_engine_if.sv - scan, paddle and ball signals shared with the pong pipeline
interface ball_motion_engine_if;
  logic       clk_VGA;
  logic [9:0] H_count;
  logic [9:0] V_count;
  logic       vid_on;
  logic       serve;
  logic [9:0] lpad_y;
  logic [9:0] rpad_y;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic       ball_on;
  logic       score_l;
  logic       score_r;
  logic       play;

  modport master (
    output clk_VGA, H_count, V_count, vid_on, serve, lpad_y, rpad_y,
    input  ball_x, ball_y, ball_on, score_l, score_r, play
  );

  modport slave (
    input  clk_VGA, H_count, V_count, vid_on, serve, lpad_y, rpad_y,
    output ball_x, ball_y, ball_on, score_l, score_r, play
  );
endinterface

// File: rtl/ball_motion_engine.sv
// rtl/ball_motion_engine.sv - ball position, bounces, paddle hits and point detection per frame
module ball_motion_engine #(
  parameter int unsigned BALL_SIZE   = 8,
  parameter int unsigned SPEED       = 2,
  parameter int unsigned LPAD_X      = 32,
  parameter int unsigned RPAD_X      = 600,
  parameter int unsigned PAD_W       = 4,
  parameter int unsigned PAD_H       = 72,
  parameter int unsigned HOLD_FRAMES = 60
) (
  input logic clk_100MHz,
  input logic rst,
  ball_motion_engine_if.slave bus
);

  localparam int unsigned HW = $clog2(HOLD_FRAMES + 1);

  // 11-bit constants so every sum and compare has headroom above the 10-bit range
  localparam logic [10:0] BS     = 11'(BALL_SIZE);
  localparam logic [10:0] SP     = 11'(SPEED);
  localparam logic [10:0] LFACE  = 11'(LPAD_X + PAD_W);
  localparam logic [10:0] RFACE  = 11'(RPAD_X);
  localparam logic [10:0] PH     = 11'(PAD_H);
  localparam logic [10:0] SCR_W  = 11'd640;
  localparam logic [10:0] SCR_H  = 11'd480;
  localparam logic [9:0]  X_MID  = 10'((640 - BALL_SIZE) / 2);
  localparam logic [9:0]  Y_MID  = 10'((480 - BALL_SIZE) / 2);
  localparam logic [9:0]  Y_BOT  = 10'(480 - BALL_SIZE);
  localparam logic [9:0]  X_RHIT = 10'(RPAD_X - BALL_SIZE);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_SCORED} state_t;

  state_t        state_q, state_d;
  logic [9:0]    x_q, x_d, y_q, y_d;
  logic          dx_q, dx_d;        // 1 = moving right
  logic          dy_q, dy_d;        // 1 = moving down
  logic          sdir_q, sdir_d;    // direction of the next serve, 1 = right
  logic [HW-1:0] hold_q, hold_d;
  logic          sl_q, sl_d, sr_q, sr_d;

  logic          frame_tick;
  logic [10:0]   x11, y11, lp11, rp11, h11, v11;
  logic          ov_l, ov_r;
  logic [9:0]    y_mv, x_mv;
  logic          dy_mv, dx_mv;
  logic          miss_l, miss_r;

  assign frame_tick = bus.clk_VGA && (bus.H_count == 10'd0) && (bus.V_count == 10'd480);

  assign x11  = {1'b0, x_q};
  assign y11  = {1'b0, y_q};
  assign lp11 = {1'b0, bus.lpad_y};
  assign rp11 = {1'b0, bus.rpad_y};
  assign h11  = {1'b0, bus.H_count};
  assign v11  = {1'b0, bus.V_count};

  // paddle overlap uses the ball's y before this frame's move
  assign ov_l = (y11 + BS > lp11) && (y11 < lp11 + PH);
  assign ov_r = (y11 + BS > rp11) && (y11 < rp11 + PH);

  // candidate y and dy for this frame, including wall bounces
  always_comb begin
    y_mv  = y_q;
    dy_mv = dy_q;
    if (dy_q) begin
      if (y11 + BS + SP >= SCR_H) begin
        y_mv  = Y_BOT;
        dy_mv = 1'b0;
      end else begin
        y_mv = y_q + SP[9:0];
      end
    end else begin
      if (y11 <= SP) begin
        y_mv  = 10'd0;
        dy_mv = 1'b1;
      end else begin
        y_mv = y_q - SP[9:0];
      end
    end
  end

  // candidate x and dx for this frame, paddle hits and missed balls
  always_comb begin
    x_mv   = x_q;
    dx_mv  = dx_q;
    miss_l = 1'b0;
    miss_r = 1'b0;
    if (!dx_q) begin
      // x >= face guarantees x - SPEED < face can be tested as x < face + SPEED without wrap
      if ((x11 >= LFACE) && (x11 < LFACE + SP) && ov_l) begin
        x_mv  = LFACE[9:0];
        dx_mv = 1'b1;
      end else if (x11 < SP) begin
        miss_l = 1'b1;
      end else begin
        x_mv = x_q - SP[9:0];
      end
    end else begin
      if ((x11 + BS <= RFACE) && (x11 + BS + SP > RFACE) && ov_r) begin
        x_mv  = X_RHIT;
        dx_mv = 1'b0;
      end else if (x11 + BS + SP > SCR_W) begin
        miss_r = 1'b1;
      end else begin
        x_mv = x_q + SP[9:0];
      end
    end
  end

  // next-state logic: serve, play, hold after a point; nothing changes between frames
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    sdir_d  = sdir_q;
    hold_d  = hold_q;
    sl_d    = 1'b0;
    sr_d    = 1'b0;
    if (frame_tick) begin
      case (state_q)
        S_IDLE: begin
          if (bus.serve) begin
            state_d = S_PLAY;
            dx_d    = sdir_q;
            dy_d    = 1'b1;
          end
        end
        S_PLAY: begin
          if (miss_l || miss_r) begin
            // a point freezes the ball: neither x nor y moves on this frame
            state_d = S_SCORED;
            hold_d  = '0;
            sr_d    = miss_l;
            sl_d    = miss_r;
            sdir_d  = miss_l;
          end else begin
            x_d  = x_mv;
            dx_d = dx_mv;
            y_d  = y_mv;
            dy_d = dy_mv;
          end
        end
        S_SCORED: begin
          hold_d = hold_q + 1'b1;
          if (hold_q == HOLD_LAST) begin
            state_d = S_IDLE;
            x_d     = X_MID;
            y_d     = Y_MID;
            hold_d  = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // state and ball registers, asynchronously cleared to the centred idle ball
  always_ff @(posedge clk_100MHz or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= X_MID;
      y_q     <= Y_MID;
      dx_q    <= 1'b1;
      dy_q    <= 1'b1;
      sdir_q  <= 1'b1;
      hold_q  <= '0;
      sl_q    <= 1'b0;
      sr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      sdir_q  <= sdir_d;
      hold_q  <= hold_d;
      sl_q    <= sl_d;
      sr_q    <= sr_d;
    end
  end

  assign bus.ball_x  = x_q;
  assign bus.ball_y  = y_q;
  assign bus.score_l = sl_q;
  assign bus.score_r = sr_q;
  assign bus.play    = (state_q == S_PLAY);
  assign bus.ball_on = bus.vid_on &&
                       (h11 >= x11) && (h11 <= x11 + BS - 11'd1) &&
                       (v11 >= y11) && (v11 <= y11 + BS - 11'd1);

endmodule

// File: tb/tb_ball_motion_engine.sv
// tb/tb_ball_motion_engine.sv - directed rallies checked against a frame-level ball model
module tb_ball_motion_engine;

  logic clk_100MHz = 1'b0;
  logic rst = 1'b1;

  ball_motion_engine_if bus();

  ball_motion_engine dut (
    .clk_100MHz (clk_100MHz),
    .rst        (rst),
    .bus        (bus)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int n_cmp = 0;
  int n_bad = 0;
  int n_print = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_print < 40) begin
        n_print++;
        $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
    end
  endtask

  // frame-level model: 0 idle, 1 play, 2 scored; directions 1 = right / down
  int m_st, m_x, m_y, m_dr, m_dd, m_hold, m_sdir, m_sl, m_sr;

  task automatic model_reset();
    m_st = 0; m_x = 316; m_y = 236; m_dr = 1; m_dd = 1;
    m_hold = 0; m_sdir = 1; m_sl = 0; m_sr = 0;
  endtask

  task automatic model_frame(input int serve, input int lp, input int rp);
    int ny, ndd, nx, ndr, pt_r, pt_l;
    if (m_st == 0) begin
      if (serve != 0) begin
        m_st = 1; m_dr = m_sdir; m_dd = 1;
      end
    end else if (m_st == 1) begin
      ny = m_y; ndd = m_dd;
      if (m_dd == 1) begin
        if (m_y + 10 >= 480) begin ny = 472; ndd = 0; end else ny = m_y + 2;
      end else begin
        if (m_y <= 2) begin ny = 0; ndd = 1; end else ny = m_y - 2;
      end
      nx = m_x; ndr = m_dr; pt_r = 0; pt_l = 0;
      if (m_dr == 0) begin
        if (m_x >= 36 && m_x - 2 < 36 && (m_y + 8 > lp) && (m_y < lp + 72)) begin
          nx = 36; ndr = 1;
        end else if (m_x < 2) pt_r = 1;
        else nx = m_x - 2;
      end else begin
        if (m_x + 8 <= 600 && m_x + 10 > 600 && (m_y + 8 > rp) && (m_y < rp + 72)) begin
          nx = 592; ndr = 0;
        end else if (m_x + 10 > 640) pt_l = 1;
        else nx = m_x + 2;
      end
      if (pt_r || pt_l) begin
        m_st = 2; m_hold = 0; m_sr = pt_r; m_sl = pt_l; m_sdir = pt_r;
      end else begin
        m_x = nx; m_y = ny; m_dr = ndr; m_dd = ndd;
      end
    end else begin
      if (m_hold == 59) begin
        m_st = 0; m_x = 316; m_y = 236; m_hold = 0;
      end else m_hold++;
    end
  endtask

  always @(posedge clk_100MHz or posedge rst) begin
    if (rst) model_reset();
    else begin
      m_sl = 0; m_sr = 0;
      if (bus.clk_VGA && bus.H_count == 10'd0 && bus.V_count == 10'd480)
        model_frame(int'(bus.serve), int'(bus.lpad_y), int'(bus.rpad_y));
    end
  end

  // every cycle out of reset, all outputs must follow the model
  always @(posedge clk_100MHz) begin
    int h, v, on;
    #2;
    if (!rst) begin
      h = int'(bus.H_count); v = int'(bus.V_count);
      on = (bus.vid_on && h >= m_x && h <= m_x + 7 && v >= m_y && v <= m_y + 7) ? 1 : 0;
      chk("model ball_x", bus.ball_x, m_x);
      chk("model ball_y", bus.ball_y, m_y);
      chk("model play", bus.play, (m_st == 1) ? 1 : 0);
      chk("model score_l", bus.score_l, m_sl);
      chk("model score_r", bus.score_r, m_sr);
      chk("model ball_on", bus.ball_on, on);
    end
  end

  int k = 0;

  // a non-tick cycle that scans pixels around the ball, including its edges
  task automatic idle_cycle();
    @(negedge clk_100MHz);
    bus.clk_VGA = 1'b0;
    bus.H_count = 10'((m_x + 1022 + (k % 12)) % 1024);
    bus.V_count = 10'((m_y + 1022 + (k % 11)) % 1024);
    bus.vid_on  = (k % 5) != 0;
    k++;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk_100MHz);
      bus.clk_VGA = 1'b1;
      bus.H_count = 10'd0;
      bus.V_count = 10'd480;
      bus.vid_on  = 1'b0;
      idle_cycle();
    end
  endtask

  task automatic chk_ball(input string name, input int x, input int y, input int p);
    chk({name, " x"}, bus.ball_x, x);
    chk({name, " y"}, bus.ball_y, y);
    chk({name, " play"}, bus.play, p);
  endtask

  initial begin
    bus.clk_VGA = 1'b0; bus.H_count = 10'd0; bus.V_count = 10'd0; bus.vid_on = 1'b0;
    bus.serve = 1'b0; bus.lpad_y = 10'd300; bus.rpad_y = 10'd400;
    repeat (3) @(negedge clk_100MHz);
    rst = 1'b0;
    chk_ball("reset", 316, 236, 0);
    chk("reset score_l", bus.score_l, 0);
    chk("reset score_r", bus.score_r, 0);

    // idle frames and near-miss ticks leave the ball centred
    tick(3);
    @(negedge clk_100MHz);
    bus.clk_VGA = 1'b1; bus.H_count = 10'd0; bus.V_count = 10'd479;
    @(negedge clk_100MHz);
    bus.clk_VGA = 1'b0; bus.H_count = 10'd0; bus.V_count = 10'd480;
    @(negedge clk_100MHz);
    bus.serve = 1'b1;
    bus.clk_VGA = 1'b1; bus.H_count = 10'd1; bus.V_count = 10'd480;
    @(negedge clk_100MHz);
    bus.serve = 1'b0; bus.clk_VGA = 1'b0;
    chk_ball("idle frames", 316, 236, 0);
    for (int h = 314; h <= 326; h++) begin
      for (int v = 234; v <= 246; v++) begin
        @(negedge clk_100MHz);
        bus.H_count = 10'(h); bus.V_count = 10'(v); bus.vid_on = 1'b1;
        #1 chk("ball_on sweep", bus.ball_on,
               (h >= 316 && h <= 323 && v >= 236 && v <= 243) ? 1 : 0);
      end
    end
    @(negedge clk_100MHz);
    bus.H_count = 10'd318; bus.V_count = 10'd238; bus.vid_on = 1'b0;
    #1 chk("ball_on blanked", bus.ball_on, 0);

    // serve right, bottom bounce, right paddle return
    bus.serve = 1'b1; tick(1); bus.serve = 1'b0;
    chk_ball("serve", 316, 236, 1);
    tick(1);   chk_ball("first move", 318, 238, 1);
    tick(117); chk_ball("bottom wall", 552, 472, 1);
    tick(2);   chk_ball("after bounce", 556, 468, 1);
    tick(19);  chk_ball("right paddle hit", 592, 430, 1);
    tick(1);   chk_ball("return left", 590, 428, 1);

    // ball slips past the left paddle: right player scores
    tick(295); chk_ball("left edge", 0, 162, 1);
    tick(1);
    chk_ball("point r", 0, 162, 0);
    chk("score_r pulse", bus.score_r, 1);
    chk("score_l quiet", bus.score_l, 0);
    @(posedge clk_100MHz); #2;
    chk("score_r one cycle", bus.score_r, 0);
    bus.serve = 1'b1; tick(30);
    chk_ball("serve ignored in hold", 0, 162, 0);
    bus.serve = 1'b0; tick(29);
    chk_ball("hold 59", 0, 162, 0);
    tick(1);   chk_ball("recentred", 316, 236, 0);

    // serve right again, ball misses the high right paddle: left player scores
    bus.rpad_y = 10'd100;
    bus.serve = 1'b1; tick(1); bus.serve = 1'b0;
    tick(158); chk_ball("right edge", 632, 392, 1);
    tick(1);
    chk("score_l pulse", bus.score_l, 1);
    chk_ball("point l", 632, 392, 0);
    tick(60);  chk_ball("recentred 2", 316, 236, 0);

    // serve goes left now; left paddle returns the ball with no point
    bus.lpad_y = 10'd430;
    bus.serve = 1'b1; tick(1); bus.serve = 1'b0;
    tick(140); chk_ball("at left face", 36, 428, 1);
    tick(1);
    chk_ball("left paddle hit", 36, 426, 1);
    chk("no score on hit", bus.score_r, 0);
    tick(1);   chk_ball("return right", 38, 424, 1);

    // reset between frames mid-rally
    tick(5);
    @(negedge clk_100MHz);
    #1 rst = 1'b1;
    #1 chk_ball("async reset", 316, 236, 0);
    chk("reset score_l mid", bus.score_l, 0);
    chk("reset score_r mid", bus.score_r, 0);
    @(negedge clk_100MHz);
    #1 rst = 1'b0;
    tick(2);   chk_ball("idle after reset", 316, 236, 0);
    bus.serve = 1'b1; tick(1); bus.serve = 1'b0;
    tick(1);   chk_ball("serve dir reset", 318, 238, 1);

    repeat (3) @(negedge clk_100MHz);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
